serial_tx_scheduler: RTL and testbench

Shares one serial transmitter between `NREQ` byte requesters, such as the microprocessor's parallel data bus and an on-chip test-pattern source. Uses round-robin arbitration. Sequences the transmitter through load, enable and completion, and enforces an inter-character idle gap. A watchdog aborts a character whose completion never arrives. Sits between the requesters and the transmitter, in the same clock domain as the transmitter's control logic.

---
 rtl/serial_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/serial_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the serial transmit path and the receiver-side
//   logic that reuses the same character width and inter-character gap.
//   - state_e           : scheduler FSM encoding (IDLE=0, LOAD=1, SEND=2, GAP=3)
//   - SERIAL_DATA_W     : default character width
//   - SERIAL_GAP_CYCLES : default idle cycles forced after each character
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int SERIAL_DATA_W     = 8;
    localparam int SERIAL_GAP_CYCLES = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: returns the first set request
//   found searching upward from ptr, wrapping at NREQ.
//   Ports:
//     req    [NREQ]  request vector
//     ptr    [ID_W]  index with highest priority this round (< NREQ)
//     gnt_id [ID_W]  index of the chosen request (ptr when none set)
//     any    [1]     at least one request is set
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    int idx;

    // Walk the priority order backwards so the last hit written is the
    // one closest to ptr, i.e. the highest-priority requester.
    always_comb begin
        gnt_id = ptr;
        any    = 1'b0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[ID_W'(idx)]) begin
                gnt_id = ID_W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler
//   Shares one serial transmitter between NREQ byte requesters using
//   round-robin arbitration. Each character goes IDLE -> LOAD -> SEND -> GAP.
//   A watchdog aborts a character whose tx_done never arrives.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     req_valid      [NREQ]         requester i has a character pending
//     req_data       [NREQ*DATA_W]  requester i data at [i*DATA_W +: DATA_W]
//     req_ready      [NREQ]         one-hot, one-cycle accept pulse
//     tx_data        [DATA_W]       character presented to the transmitter
//     tx_load        [1]            one-cycle load strobe
//     tx_enable      [1]            high while the transmitter shifts
//     tx_done        [1]            one-cycle character-sent pulse (input)
//     grant_id       [clog2(NREQ)]  current/last granted requester
//     busy           [1]            FSM not in IDLE
//     timeout_err    [1]            one-cycle pulse on watchdog abort
//     dbg_state      [2]            FSM state, for observation only
//
//   Requester handshake: a requester raises req_valid with stable req_data
//   and holds both until it sees req_ready for its index. Arbitration only
//   samples req_valid in IDLE; the character is captured at that moment, so
//   once sampled it is sent even if req_valid drops before req_ready.
//   req_ready accompanies tx_load in the LOAD cycle. A reset before LOAD
//   completes leaves the requester to resubmit.
module serial_tx_scheduler
    import serial_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int DATA_W         = SERIAL_DATA_W,
    parameter int GAP_CYCLES     = SERIAL_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_load,
    output logic                      tx_enable,
    input  logic                      tx_done,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      timeout_err,
    output state_e                    dbg_state
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [NREQ-1:0]  ONE_HOT0  = NREQ'(1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NREQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic [NREQ-1:0]    req_ready_q;
    logic               tx_load_q;
    logic               tx_enable_q;
    logic               timeout_err_q;
    logic               busy_q;
    logic [WD_W-1:0]    wd_q;
    logic [GAP_W-1:0]   gap_q;

    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic [ID_W-1:0]    rr_ptr_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // Priority moves to the requester just after the one being loaded.
    assign rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

    // Strobes are registered and set on the transition into the state
    // they belong to, so every output is a flop with no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            tx_load_q     <= 1'b0;
            tx_enable_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            wd_q          <= '0;
            gap_q         <= '0;
        end else begin
            req_ready_q   <= '0;
            tx_load_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        tx_data_q   <= req_data[arb_id*DATA_W +: DATA_W];
                        grant_id_q  <= arb_id;
                        req_ready_q <= ONE_HOT0 << arb_id;
                        tx_load_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rr_ptr_q    <= rr_ptr_d;
                    wd_q        <= '0;
                    tx_enable_q <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
                    // tx_done is checked first so it wins a tie with expiry.
                    if (tx_done) begin
                        tx_enable_q <= 1'b0;
                        gap_q       <= '0;
                        state_q     <= ST_GAP;
                    end else if (wd_q == WD_LAST) begin
                        timeout_err_q <= 1'b1;
                        tx_enable_q   <= 1'b0;
                        gap_q         <= '0;
                        state_q       <= ST_GAP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    busy_q      <= 1'b0;
                    tx_enable_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_load     = tx_load_q;
    assign tx_enable   = tx_enable_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler
//   Directed bench for serial_tx_scheduler with NREQ=2, DATA_W=8,
//   GAP_CYCLES=4, TIMEOUT_CYCLES=16. Inputs are driven and outputs sampled
//   on the falling edge; the DUT acts on the rising edge.
module tb_serial_tx_scheduler;
    import serial_pkg::*;

    localparam int NREQ   = 2;
    localparam int DATA_W = 8;
    localparam int GAP_N  = 4;
    localparam int TO_N   = 16;

    // ---------------- clock / reset / DUT ----------------
    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_load;
    logic                   tx_enable;
    logic                   tx_done;
    logic [0:0]             grant_id;
    logic                   busy;
    logic                   timeout_err;
    state_e                 dbg_state;

    always #5 clk = ~clk;

    serial_tx_scheduler #(
        .NREQ           (NREQ),
        .DATA_W         (DATA_W),
        .GAP_CYCLES     (GAP_N),
        .TIMEOUT_CYCLES (TO_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_enable   (tx_enable),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                exp_id_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    // done_after: enable cycle on which tx_done is pulsed (0 = never).
    // stray: pulse tx_done in the first GAP cycle.
    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        int         done_after;
        logic       stray;
        int         exp_grant;
        logic [7:0] exp_data;
        int         exp_en;
        logic       exp_to;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver tasks ----------------
    task automatic run_char(input vec_t v, input int row);
        int waits;
        int en_cnt;
        int gap_len;
        logic bad;
        logic [1:0] one;
        string tag;
        one = 2'b01;
        tag = $sformatf("row%0d", row);
        req_valid = v.valid;
        req_data  = {v.d1, v.d0};
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!tx_load && waits < 20);
        check({tag, "_load_latency"}, 32'(waits), 32'd1);
        check({tag, "_req_ready"}, 32'(req_ready), 32'(one << v.exp_grant));
        check({tag, "_tx_data"}, 32'(tx_data), 32'(v.exp_data));
        check({tag, "_grant_id"}, 32'(grant_id), 32'(v.exp_grant));
        check({tag, "_busy_load"}, 32'(busy), 32'd1);
        req_valid = '0;
        en_cnt = 0;
        waits  = 0;
        forever begin
            @(negedge clk);
            waits++;
            if (tx_enable && waits < 40) begin
                en_cnt++;
                tx_done = (en_cnt == v.done_after);
            end else begin
                tx_done = v.stray;
                break;
            end
        end
        check({tag, "_enable_cycles"}, 32'(en_cnt), 32'(v.exp_en));
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'(v.exp_to));
        gap_len = 1;
        bad = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!busy || gap_len >= 20) break;
            gap_len++;
            if (tx_load || tx_enable || timeout_err || (|req_ready)) bad = 1'b1;
        end
        check({tag, "_gap_len"}, 32'(gap_len), 32'(GAP_N));
        check({tag, "_gap_strobes"}, 32'(bad), 32'd0);
        check({tag, "_idle_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic finish_char(input string tag);
        int c;
        c = 0;
        while (c < 100) begin
            @(negedge clk);
            c++;
            tx_done = tx_enable;
            if (!busy) break;
        end
        tx_done = 1'b0;
        check({tag, "_drain"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_tx_load"}, 32'(tx_load), 32'd0);
        check({tag, "_tx_enable"}, 32'(tx_enable), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic reset_mid_send(input string tag, input logic [1:0] v_before,
                                  input logic [1:0] v_after, input logic [15:0] data,
                                  input int exp_grant, input logic [7:0] exp_data);
        int waits;
        logic [1:0] one;
        one = 2'b01;
        req_data  = data;
        req_valid = v_before;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!tx_load && waits < 20);
        check({tag, "_pre_load"}, 32'(tx_load), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_pre_enable"}, 32'(tx_enable), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values({tag, "_rst"});
        @(negedge clk);
        rst = 1'b0;
        req_valid = v_after;
        @(negedge clk);
        check({tag, "_post_load"}, 32'(tx_load), 32'd1);
        check({tag, "_post_grant"}, 32'(grant_id), 32'(exp_grant));
        check({tag, "_post_data"}, 32'(tx_data), 32'(exp_data));
        check({tag, "_post_ready"}, 32'(req_ready), 32'(one << exp_grant));
        req_valid = '0;
        finish_char(tag);
    endtask

    // ---------------- test ----------------
    initial begin
        int cyc;
        int cnt;
        vecs[0] = '{2'b01, 8'hA5, 8'h5A, 10, 1'b0, 0, 8'hA5, 10, 1'b0};
        vecs[1] = '{2'b01, 8'h3C, 8'h00,  3, 1'b1, 0, 8'h3C,  3, 1'b0};
        vecs[2] = '{2'b11, 8'h11, 8'h22,  5, 1'b0, 1, 8'h22,  5, 1'b0};
        vecs[3] = '{2'b11, 8'h77, 8'h88,  0, 1'b0, 0, 8'h77, 16, 1'b1};
        vecs[4] = '{2'b10, 8'h00, 8'hC3, 16, 1'b0, 1, 8'hC3, 16, 1'b0};
        vecs[5] = '{2'b10, 8'h00, 8'hE1,  1, 1'b0, 1, 8'hE1,  1, 1'b0};
        vecs[6] = '{2'b11, 8'h0F, 8'hF0,  2, 1'b0, 0, 8'h0F,  2, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Contention: both requesters held valid, grants must alternate.
        exp_q    = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_id_q = '{0, 1, 0, 1};
        req_data  = {8'h22, 8'h11};
        req_valid = 2'b11;
        cyc = 0;
        cnt = 0;
        while ((exp_q.size() > 0 || busy) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            tx_done = 1'b0;
            if (tx_load) begin
                if (exp_q.size() > 0) begin
                    check("rr_tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                    check("rr_grant_id", 32'(grant_id), 32'(exp_id_q.pop_front()));
                end else begin
                    check("rr_extra_load", 32'(tx_load), 32'd0);
                end
                if (exp_q.size() == 0) req_valid = '0;
                cnt = 0;
            end else if (tx_enable) begin
                cnt++;
                if (cnt == 2) tx_done = 1'b1;
            end
        end
        tx_done = 1'b0;
        check("rr_all_grants_seen", 32'(exp_q.size()), 32'd0);
        check("rr_drained", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) run_char(vecs[i], i);

        // Stray tx_done while idle must do nothing.
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_idle_busy", 32'(busy), 32'd0);
        check("stray_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("stray_idle_strobes", 32'({tx_load, tx_enable, timeout_err, req_ready}), 32'd0);
        @(negedge clk);
        check("stray_idle_busy2", 32'(busy), 32'd0);

        // Reset mid-character clears rr_ptr: with both valid afterwards,
        // requester 0 wins even though requester 1 had priority before.
        reset_mid_send("rst_rr", 2'b01, 2'b11, {8'hB4, 8'h4B}, 0, 8'h4B);
        // Reset mid-character with requester 1 still pending.
        reset_mid_send("rst_req1", 2'b10, 2'b10, {8'h9C, 8'h00}, 1, 8'h9C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
